// File: rtl/cu_fsm_pkg.sv
// cu_fsm_pkg: state encodings and opcode constants shared by the Otter control unit
package cu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_INTRPT = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPCODE_OP_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_INTRPT = 7'b1110011;

endpackage

// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle fetch/exec/writeback sequencer with interrupt entry and memory-wait watchdog
module cu_fsm
    import cu_fsm_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func,
    input  logic       intrpt,
    input  logic       mie,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       rfile_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_write,
    output logic       intrpt_taken,
    output logic       bus_fault,
    output logic [2:0] state_dbg
);

    state_t     state, state_n, done_st;
    logic [7:0] wait_cnt;
    logic       pending, waiting, fault;
    logic       is_ld, is_st, is_sys, is_wr;
    logic       unused_func;

    assign unused_func = ^func[2:1];
    assign state_dbg   = state;

    always_comb begin
        is_ld   = opcode == OPCODE_LOAD;
        is_st   = opcode == OPCODE_STORE;
        is_sys  = opcode == OPCODE_INTRPT;
        is_wr   = opcode inside {OPCODE_OP_REG, OPCODE_OP_IMM, OPCODE_LUI,
                                 OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR};
        waiting = (state == ST_FETCH && !imem_ready)
               || (state == ST_EXEC && (is_ld || is_st) && !dmem_ready);
        // the wait that would reach the limit faults unless ready rescues it
        fault   = waiting && wait_cnt == 8'(WAIT_LIMIT - 1);
        done_st = pending ? ST_INTRPT : ST_FETCH;
        pc_write     = 1'b0;
        rfile_write  = 1'b0;
        mem_rden1    = 1'b0;
        mem_rden2    = 1'b0;
        mem_we2      = 1'b0;
        csr_write    = 1'b0;
        intrpt_taken = 1'b0;
        state_n      = state;
        case (state)
            ST_INIT: state_n = ST_FETCH;
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                state_n   = fault ? ST_HALT : imem_ready ? ST_EXEC : ST_FETCH;
            end
            ST_EXEC: begin
                if (is_ld) begin
                    mem_rden2 = 1'b1;
                    state_n   = fault ? ST_HALT : dmem_ready ? ST_WB : ST_EXEC;
                end else if (is_st) begin
                    mem_we2  = 1'b1;
                    pc_write = dmem_ready;
                    state_n  = fault ? ST_HALT : dmem_ready ? done_st : ST_EXEC;
                end else begin
                    pc_write    = 1'b1;
                    rfile_write = is_wr || (is_sys && func[0]);
                    csr_write   = is_sys && func[0];
                    // mret defers any pending trap to the next boundary
                    state_n     = (is_sys && !func[0]) ? ST_FETCH : done_st;
                end
            end
            ST_WB: begin
                rfile_write = 1'b1;
                pc_write    = 1'b1;
                state_n     = done_st;
            end
            ST_INTRPT: begin
                intrpt_taken = 1'b1;
                pc_write     = 1'b1;
                state_n      = ST_FETCH;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            wait_cnt  <= 8'd0;
            pending   <= 1'b0;
            bus_fault <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= (state_n != state) ? 8'd0 : waiting ? wait_cnt + 8'd1 : wait_cnt;
            pending   <= (pending & (state != ST_INTRPT)) | (intrpt & mie);
            bus_fault <= bus_fault | fault;
        end
    end

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm: directed-vector bench for cu_fsm with a short watchdog limit
module tb_cu_fsm;
    import cu_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = OPCODE_OP_REG;
    logic [2:0] func = 3'b000;
    logic       intrpt = 1'b0;
    logic       mie = 1'b0;
    logic       imem_ready = 1'b1;
    logic       dmem_ready = 1'b1;
    logic       pc_write, rfile_write, mem_rden1, mem_rden2, mem_we2;
    logic       csr_write, intrpt_taken, bus_fault;
    logic [2:0] state_dbg;
    logic [10:0] obs;
    int         vectors = 0;
    int         miscompares = 0;

    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_RD1  = 7'b0010000;
    localparam logic [6:0] E_RD2  = 7'b0001000;
    localparam logic [6:0] E_WE   = 7'b0000100;
    localparam logic [6:0] E_PCWE = 7'b1000100;
    localparam logic [6:0] E_PC   = 7'b1000000;
    localparam logic [6:0] E_PCRF = 7'b1100000;
    localparam logic [6:0] E_CSR  = 7'b1100010;
    localparam logic [6:0] E_TRAP = 7'b1000001;

    cu_fsm #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .intrpt(intrpt), .mie(mie), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .rfile_write(rfile_write), .mem_rden1(mem_rden1),
        .mem_rden2(mem_rden2), .mem_we2(mem_we2), .csr_write(csr_write),
        .intrpt_taken(intrpt_taken), .bus_fault(bus_fault), .state_dbg(state_dbg)
    );

    assign obs = {pc_write, rfile_write, mem_rden1, mem_rden2, mem_we2,
                  csr_write, intrpt_taken, bus_fault, state_dbg};

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] en, input logic bf, input logic [2:0] st);
        logic [10:0] e;
        e = {en, bf, st};
        @(negedge clk);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    logic [6:0] m_op [3];
    logic [2:0] m_fn [3];
    logic [6:0] m_en [3];

    initial begin
        m_op = '{OPCODE_INTRPT, OPCODE_BRANCH, OPCODE_INTRPT};
        m_fn = '{3'b001, 3'b000, 3'b000};
        m_en = '{E_CSR, E_PC, E_PC};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_init", E_NONE, 1'b0, 3'd0);
        nxt(); chk("rtype_fetch", E_RD1, 1'b0, 3'd1);
        nxt(); chk("rtype_exec", E_PCRF, 1'b0, 3'd2);
        nxt(); opcode = OPCODE_LOAD; dmem_ready = 1'b0;
        chk("rtype_refetch", E_RD1, 1'b0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            nxt(); chk("load_wait", E_RD2, 1'b0, 3'd2);
        end
        nxt(); dmem_ready = 1'b1;
        chk("load_ready", E_RD2, 1'b0, 3'd2);
        nxt(); chk("load_wb", E_PCRF, 1'b0, 3'd3);
        nxt(); opcode = OPCODE_STORE; dmem_ready = 1'b0; intrpt = 1'b1; mie = 1'b1;
        chk("store_fetch", E_RD1, 1'b0, 3'd1);
        nxt(); intrpt = 1'b0;
        chk("store_wait", E_WE, 1'b0, 3'd2);
        nxt(); dmem_ready = 1'b1;
        chk("store_done", E_PCWE, 1'b0, 3'd2);
        nxt(); chk("trap_entry", E_TRAP, 1'b0, 3'd4);
        nxt(); chk("trap_refetch", E_RD1, 1'b0, 3'd1);
        nxt(); opcode = OPCODE_OP_REG;
        chk("post_trap_exec", E_PCRF, 1'b0, 3'd2);
        nxt(); chk("pending_cleared", E_RD1, 1'b0, 3'd1);
        intrpt = 1'b1; mie = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opcode = m_op[i]; func = m_fn[i];
            nxt(); chk("masked_exec", m_en[i], 1'b0, 3'd2);
            nxt(); chk("masked_fetch", E_RD1, 1'b0, 3'd1);
        end
        opcode = OPCODE_INTRPT; func = 3'b000; mie = 1'b1;
        nxt(); intrpt = 1'b0;
        chk("mret_exec", E_PC, 1'b0, 3'd2);
        nxt(); opcode = OPCODE_OP_IMM;
        chk("mret_no_trap", E_RD1, 1'b0, 3'd1);
        nxt(); chk("opimm_exec", E_PCRF, 1'b0, 3'd2);
        nxt(); rst = 1'b1;
        chk("trap_before_rst", E_TRAP, 1'b0, 3'd4);
        nxt(); rst = 1'b0; imem_ready = 1'b0;
        chk("rst_in_trap", E_NONE, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            nxt(); chk("imem_wait", E_RD1, 1'b0, 3'd1);
        end
        nxt(); chk("wd_halt", E_NONE, 1'b1, 3'd5);
        nxt(); chk("halt_sticky", E_NONE, 1'b1, 3'd5);
        rst = 1'b1;
        nxt(); rst = 1'b0;
        chk("halt_reset", E_NONE, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            nxt(); chk("edge_wait", E_RD1, 1'b0, 3'd1);
        end
        nxt(); imem_ready = 1'b1;
        chk("edge_ready", E_RD1, 1'b0, 3'd1);
        nxt(); chk("edge_exec", E_PCRF, 1'b0, 3'd2);
        nxt(); opcode = OPCODE_LOAD; dmem_ready = 1'b0;
        chk("dwd_fetch", E_RD1, 1'b0, 3'd1);
        for (int i = 0; i < 4; i++) begin
            nxt(); chk("dmem_wait", E_RD2, 1'b0, 3'd2);
        end
        nxt(); chk("dwd_halt", E_NONE, 1'b1, 3'd5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
